// File: rtl/sr_dmem.sv
// sr_dmem: word-organised data memory behind the single-cycle CPU's
// data-memory port. Byte/half/word lanes, sign/zero-extended loads,
// stores committed on the rising edge, a sticky illegal-access flag with
// first-fault address capture, and a free-running accepted-store counter.
//
// Port protocol: there is no valid/ready handshake. The CPU drives the
// port every cycle, so every cycle is an access. dmWe is a store strobe
// sampled at the rising edge. The store is accepted only when the access
// is legal. Loads are purely combinational. When idle, the CPU must hold
// a legal size and address, for example w_word with address 0.
module sr_dmem #(
  parameter int DEPTH_W = 6,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      dmAddr,
  input  logic [31:0]      dmDataW,
  input  logic             dmWe,
  input  logic             w_byte,
  input  logic             w_half,
  input  logic             w_word,
  input  logic             sign,
  output logic [31:0]      dmDataR,
  input  logic             errClr,
  output logic             err,
  output logic [31:0]      errAddr,
  output logic [CNT_W-1:0] storeCnt
);

  localparam int DEPTH = 1 << DEPTH_W;

  logic [31:0]        mem_q [DEPTH];
  logic               err_q, err_d;
  logic [31:0]        err_addr_q, err_addr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [DEPTH_W-1:0] idx;
  logic [1:0]         lane;
  logic               size_ok, align_ok, range_ok, legal, store_en;
  logic [31:0]        rd_word, wr_word;
  logic [7:0]         rd_byte;
  logic [15:0]        rd_half;

  assign idx  = dmAddr[DEPTH_W+1:2];
  assign lane = dmAddr[1:0];

  // Classify the current access: exactly one size, aligned, and inside the array.
  always_comb begin
    size_ok  = ({w_byte, w_half, w_word} == 3'b100) ||
               ({w_byte, w_half, w_word} == 3'b010) ||
               ({w_byte, w_half, w_word} == 3'b001);
    align_ok = 1'b1;
    if (w_half) align_ok = (dmAddr[0] == 1'b0);
    if (w_word) align_ok = (dmAddr[1:0] == 2'b00);
    range_ok = (dmAddr[31:DEPTH_W+2] == '0);
    legal    = size_ok && align_ok && range_ok;
    store_en = legal && dmWe;
  end

  assign rd_word = mem_q[idx];

  // Load path: pick the lane(s) from the addressed word and extend to 32 bits.
  always_comb begin
    rd_byte = 8'h00;
    case (lane)
      2'd0: rd_byte = rd_word[7:0];
      2'd1: rd_byte = rd_word[15:8];
      2'd2: rd_byte = rd_word[23:16];
      default: rd_byte = rd_word[31:24];
    endcase
    rd_half = dmAddr[1] ? rd_word[31:16] : rd_word[15:0];
    dmDataR = 32'h0000_0000;
    if (legal) begin
      if (w_byte)      dmDataR = {{24{sign & rd_byte[7]}}, rd_byte};
      else if (w_half) dmDataR = {{16{sign & rd_half[15]}}, rd_half};
      else             dmDataR = rd_word;
    end
  end

  // Store merge: overwrite only the addressed lane(s) of the current word.
  always_comb begin
    wr_word = rd_word;
    if (w_byte) begin
      case (lane)
        2'd0: wr_word[7:0]   = dmDataW[7:0];
        2'd1: wr_word[15:8]  = dmDataW[7:0];
        2'd2: wr_word[23:16] = dmDataW[7:0];
        default: wr_word[31:24] = dmDataW[7:0];
      endcase
    end else if (w_half) begin
      if (dmAddr[1]) wr_word[31:16] = dmDataW[15:0];
      else           wr_word[15:0]  = dmDataW[15:0];
    end else begin
      wr_word = dmDataW;
    end
  end

  // Next state for the sticky error. A new fault in the same cycle as errClr takes priority.
  always_comb begin
    err_d      = err_q;
    err_addr_d = err_addr_q;
    if (!legal) begin
      err_d      = 1'b1;
      err_addr_d = (err_q && !errClr) ? err_addr_q : dmAddr;
    end else if (errClr) begin
      err_d      = 1'b0;
      err_addr_d = 32'h0000_0000;
    end
  end

  // Accepted stores increment the counter, which wraps naturally at 2^CNT_W.
  always_comb begin
    cnt_d = cnt_q;
    if (store_en) cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  // Memory array: cleared on reset, a legal strobed store commits the merged word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 32'h0000_0000;
    end else if (store_en) begin
      mem_q[idx] <= wr_word;
    end
  end

  // Error flag, first-fault address and store counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q      <= 1'b0;
      err_addr_q <= 32'h0000_0000;
      cnt_q      <= '0;
    end else begin
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
      cnt_q      <= cnt_d;
    end
  end

  assign err      = err_q;
  assign errAddr  = err_addr_q;
  assign storeCnt = cnt_q;

endmodule

// File: tb/tb_sr_dmem.sv
// Testbench for sr_dmem: a table of directed vectors with hand-computed
// results, plus hand-written sequences for read-during-write, counter
// wrap and asynchronous reset in the middle of a store stream.
module tb_sr_dmem;

  logic        clk;
  logic        rst_n;
  logic [31:0] dmAddr;
  logic [31:0] dmDataW;
  logic        dmWe;
  logic        w_byte, w_half, w_word;
  logic        sign;
  logic [31:0] dmDataR;
  logic        errClr;
  logic        err;
  logic [31:0] errAddr;
  logic [15:0] storeCnt;

  int n_chk  = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];

  sr_dmem #(.DEPTH_W(6), .CNT_W(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .dmAddr   (dmAddr),
    .dmDataW  (dmDataW),
    .dmWe     (dmWe),
    .w_byte   (w_byte),
    .w_half   (w_half),
    .w_word   (w_word),
    .sign     (sign),
    .dmDataR  (dmDataR),
    .errClr   (errClr),
    .err      (err),
    .errAddr  (errAddr),
    .storeCnt (storeCnt)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        we;
    logic [2:0]  sz;      // {byte, half, word}
    logic        sgn;
    logic        clr;
    logic [31:0] exp_rd;  // dmDataR before the edge
    logic        exp_err; // after the edge
    logic [31:0] exp_ea;
    logic [15:0] exp_cnt;
  } vec_t;

  localparam int NV = 31;
  vec_t vtab [NV];

  function automatic vec_t mk(input logic [31:0] a, input logic [31:0] d, input logic we,
                              input logic [2:0] sz, input logic sg, input logic cl,
                              input logic [31:0] rd, input logic e, input logic [31:0] ea,
                              input logic [15:0] c);
    vec_t v;
    v.addr = a; v.data = d; v.we = we; v.sz = sz; v.sgn = sg; v.clr = cl;
    v.exp_rd = rd; v.exp_err = e; v.exp_ea = ea; v.exp_cnt = c;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic we,
                       input logic [2:0] sz, input logic sg, input logic cl);
    dmAddr = a; dmDataW = d; dmWe = we;
    {w_byte, w_half, w_word} = sz;
    sign = sg; errClr = cl;
  endtask

  // Driver: set inputs at the falling edge, check the load path, then the registers after the rising edge.
  task automatic apply(input vec_t v, input int k);
    @(negedge clk);
    drive(v.addr, v.data, v.we, v.sz, v.sgn, v.clr);
    #1;
    chk($sformatf("v%0d rd", k), dmDataR, v.exp_rd);
    @(posedge clk);
    #1;
    chk($sformatf("v%0d err", k), {31'b0, err}, {31'b0, v.exp_err});
    chk($sformatf("v%0d errAddr", k), errAddr, v.exp_ea);
    chk($sformatf("v%0d cnt", k), {16'b0, storeCnt}, {16'b0, v.exp_cnt});
  endtask

  localparam logic [2:0] SB = 3'b100, SH = 3'b010, SW = 3'b001;

  initial begin
    rst_n = 1'b0;
    drive(32'h0, 32'h0, 1'b0, SW, 1'b0, 1'b0);

    //            addr          data          we   sz      sg   clr  exp_rd        err  ea            cnt
    vtab[0]  = mk(32'h0000_0000, 32'h0,        1'b0, SW,     1'b0, 1'b0, 32'h0000_0000, 1'b0, 32'h0,         16'd0);
    vtab[1]  = mk(32'h0000_0010, 32'hDEADBEEF, 1'b1, SW,     1'b0, 1'b0, 32'h0000_0000, 1'b0, 32'h0,         16'd1);
    vtab[2]  = mk(32'h0000_0010, 32'h0,        1'b0, SW,     1'b0, 1'b0, 32'hDEADBEEF, 1'b0, 32'h0,         16'd1);
    vtab[3]  = mk(32'h0000_0011, 32'h0000_0055, 1'b1, SB,    1'b0, 1'b0, 32'h0000_00BE, 1'b0, 32'h0,         16'd2);
    vtab[4]  = mk(32'h0000_0010, 32'h0,        1'b0, SW,     1'b0, 1'b0, 32'hDEAD55EF, 1'b0, 32'h0,         16'd2);
    vtab[5]  = mk(32'h0000_0013, 32'h0,        1'b0, SB,     1'b1, 1'b0, 32'hFFFFFFDE, 1'b0, 32'h0,         16'd2);
    vtab[6]  = mk(32'h0000_0013, 32'h0,        1'b0, SB,     1'b0, 1'b0, 32'h0000_00DE, 1'b0, 32'h0,         16'd2);
    vtab[7]  = mk(32'h0000_0012, 32'h0000_8001, 1'b1, SH,    1'b0, 1'b0, 32'h0000_DEAD, 1'b0, 32'h0,         16'd3);
    vtab[8]  = mk(32'h0000_0010, 32'h0,        1'b0, SW,     1'b0, 1'b0, 32'h800155EF, 1'b0, 32'h0,         16'd3);
    vtab[9]  = mk(32'h0000_0012, 32'h0,        1'b0, SH,     1'b1, 1'b0, 32'hFFFF8001, 1'b0, 32'h0,         16'd3);
    vtab[10] = mk(32'h0000_0012, 32'h0,        1'b0, SH,     1'b0, 1'b0, 32'h0000_8001, 1'b0, 32'h0,         16'd3);
    vtab[11] = mk(32'h0000_0010, 32'h0,        1'b0, SH,     1'b1, 1'b0, 32'h0000_55EF, 1'b0, 32'h0,         16'd3);
    vtab[12] = mk(32'h0000_0010, 32'h0,        1'b0, SB,     1'b1, 1'b0, 32'hFFFFFFEF, 1'b0, 32'h0,         16'd3);
    vtab[13] = mk(32'h0000_0011, 32'h0,        1'b0, SB,     1'b1, 1'b0, 32'h0000_0055, 1'b0, 32'h0,         16'd3);
    vtab[14] = mk(32'h0000_0022, 32'h12345678, 1'b1, SW,     1'b0, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_0022, 16'd3);
    vtab[15] = mk(32'h0000_0020, 32'h0,        1'b0, SW,     1'b0, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_0022, 16'd3);
    vtab[16] = mk(32'h0000_0101, 32'h0,        1'b0, SH,     1'b0, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_0022, 16'd3);
    vtab[17] = mk(32'h0000_0010, 32'h0,        1'b0, SW,     1'b0, 1'b1, 32'h800155EF, 1'b0, 32'h0,         16'd3);
    vtab[18] = mk(32'h0000_0400, 32'h0,        1'b0, SB,     1'b0, 1'b1, 32'h0000_0000, 1'b1, 32'h0000_0400, 16'd3);
    vtab[19] = mk(32'h0000_0000, 32'h0,        1'b0, SW,     1'b0, 1'b1, 32'h0000_0000, 1'b0, 32'h0,         16'd3);
    vtab[20] = mk(32'h0000_0014, 32'hAAAAAAAA, 1'b1, 3'b101, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_0014, 16'd3);
    vtab[21] = mk(32'h0000_0014, 32'h0,        1'b0, SW,     1'b0, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_0014, 16'd3);
    vtab[22] = mk(32'h0000_0008, 32'h0,        1'b0, 3'b000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_0014, 16'd3);
    vtab[23] = mk(32'h8000_0010, 32'h0,        1'b0, SW,     1'b0, 1'b1, 32'h0000_0000, 1'b1, 32'h8000_0010, 16'd3);
    vtab[24] = mk(32'h0000_0013, 32'h0,        1'b0, SH,     1'b0, 1'b0, 32'h0000_0000, 1'b1, 32'h8000_0010, 16'd3);
    vtab[25] = mk(32'h0000_0000, 32'h0,        1'b0, SW,     1'b0, 1'b1, 32'h0000_0000, 1'b0, 32'h0,         16'd3);
    vtab[26] = mk(32'h0000_001E, 32'hFFFF7F80, 1'b1, SH,     1'b1, 1'b0, 32'h0000_0000, 1'b0, 32'h0,         16'd4);
    vtab[27] = mk(32'h0000_001C, 32'h0,        1'b0, SW,     1'b0, 1'b0, 32'h7F80_0000, 1'b0, 32'h0,         16'd4);
    vtab[28] = mk(32'h0000_001F, 32'h0,        1'b0, SB,     1'b1, 1'b0, 32'h0000_007F, 1'b0, 32'h0,         16'd4);
    vtab[29] = mk(32'h0000_0200, 32'h5555AAAA, 1'b1, SW,     1'b0, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_0200, 16'd4);
    vtab[30] = mk(32'h0000_001C, 32'h0,        1'b0, SW,     1'b0, 1'b1, 32'h7F80_0000, 1'b0, 32'h0,         16'd4);

    // Reset values while reset is held
    #1;
    chk("reset err", {31'b0, err}, 32'h0);
    chk("reset errAddr", errAddr, 32'h0);
    chk("reset cnt", {16'b0, storeCnt}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < NV; k++) apply(vtab[k], k);

    // Read-during-write at 0x4: old contents while strobing, new contents next cycle
    exp_q.push_back(32'h0000_0000);
    exp_q.push_back(32'hCAFEF00D);
    exp_q.push_back(32'hCAFEF00D);
    exp_q.push_back(32'h11112222);
    @(negedge clk);
    drive(32'h4, 32'hCAFEF00D, 1'b1, SW, 1'b0, 1'b0);
    #1 chk("rdw old0", dmDataR, exp_q.pop_front());
    @(posedge clk); #1 chk("rdw cnt5", {16'b0, storeCnt}, 32'd5);
    @(negedge clk); dmWe = 1'b0;
    #1 chk("rdw new0", dmDataR, exp_q.pop_front());
    @(negedge clk);
    drive(32'h4, 32'h11112222, 1'b1, SW, 1'b0, 1'b0);
    #1 chk("rdw old1", dmDataR, exp_q.pop_front());
    @(posedge clk); #1 chk("rdw cnt6", {16'b0, storeCnt}, 32'd6);
    @(negedge clk); dmWe = 1'b0;
    #1 chk("rdw new1", dmDataR, exp_q.pop_front());

    // Counter wrap: 65530 more stores bring 6 back round to 0
    @(negedge clk);
    drive(32'h8, 32'h0BADF00D, 1'b1, SW, 1'b0, 1'b0);
    repeat (65529) @(posedge clk);
    #1 chk("wrap cnt ffff", {16'b0, storeCnt}, 32'h0000_FFFF);
    @(posedge clk);
    #1 chk("wrap cnt 0", {16'b0, storeCnt}, 32'h0);
    chk("wrap data", dmDataR, 32'h0BADF00D);

    // Put an error on record, then assert reset mid-store
    @(negedge clk);
    drive(32'h9, 32'h0, 1'b1, SW, 1'b0, 1'b0);
    @(posedge clk);
    #1 chk("pre-rst err", {31'b0, err}, 32'h1);
    chk("pre-rst errAddr", errAddr, 32'h9);
    chk("pre-rst cnt", {16'b0, storeCnt}, 32'h0);
    @(negedge clk);
    drive(32'h8, 32'h5A5A5A5A, 1'b1, SW, 1'b0, 1'b0);
    @(posedge clk);
    #1 chk("mid cnt", {16'b0, storeCnt}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst cnt", {16'b0, storeCnt}, 32'h0);
    chk("async rst err", {31'b0, err}, 32'h0);
    chk("async rst errAddr", errAddr, 32'h0);
    chk("async rst mem 0x8", dmDataR, 32'h0);
    dmAddr = 32'h4;  #1 chk("async rst mem 0x4", dmDataR, 32'h0);
    dmAddr = 32'h1C; #1 chk("async rst mem 0x1c", dmDataR, 32'h0);
    dmAddr = 32'h10; #1 chk("async rst mem 0x10", dmDataR, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    drive(32'h10, 32'h0, 1'b0, SW, 1'b0, 1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    #1 chk("post rst mem 0x10", dmDataR, 32'h0);
    chk("post rst cnt", {16'b0, storeCnt}, 32'h0);
    chk("post rst err", {31'b0, err}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
